io_seq_adder: RTL and testbench

- Parametrised, sequential successor to the combinational GPIO adder in the user project area.
- Receives two operands over a narrow GPIO data path, NIB bits per beat, least-significant beat first, with a valid/ready handshake.
- Computes add, subtract or accumulate on WIDTH-bit operands, then streams the result back NIB bits per beat, with a carry/borrow flag.
- Instantiated by user_project_wrapper; the wrapper maps its ports onto io_in/io_out/io_oeb.

---
 rtl/io_seq_adder_pkg.sv | 32 +++
 rtl/io_nib_shift_reg.sv | 56 +++++
 rtl/io_seq_adder.sv | 255 +++++++++++++++++++++++++
 tb/tb_io_seq_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_adder_pkg.sv
// ---------------------------------------------------------------------------
// io_seq_adder_pkg
//   Shared encodings for the nibble-serial adder:
//     op_mode_t : operation selected with beat 0 of operand A
//     state_t   : control FSM states (also exported on the debug state port)
//   cnt_width() : width of a beat counter covering 0..beats-1
// ---------------------------------------------------------------------------
package io_seq_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  // A counter for a single beat still needs one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage : io_seq_adder_pkg

// File: rtl/io_nib_shift_reg.sv
// ---------------------------------------------------------------------------
// io_nib_shift_reg
//   WIDTH-bit register moved NIB bits at a time.
//   Priority: parallel load > shift-in > shift-out.
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-high reset (clears to 0)
//     load_i, par_i  : parallel load of the whole word
//     shift_in_i     : shift right, nib_i enters at the MS end
//     nib_i          : nibble shifted in
//     shift_out_i    : shift right, zeros enter at the MS end
//     data_o         : full register contents
//     nib_o          : LS nibble (the beat currently presented)
// ---------------------------------------------------------------------------
module io_nib_shift_reg #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             shift_in_i,
  input  logic [NIB-1:0]   nib_i,
  input  logic             shift_out_i,
  output logic [WIDTH-1:0] data_o,
  output logic [NIB-1:0]   nib_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Loading LS beat first into the MS end means that after WIDTH/NIB
  // shift-ins beat 0 has walked down to bits [NIB-1:0].
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = par_i;
    end else if (shift_in_i) begin
      data_d = {nib_i, data_q[WIDTH-1:NIB]};
    end else if (shift_out_i) begin
      data_d = {{NIB{1'b0}}, data_q[WIDTH-1:NIB]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign nib_o  = data_q[NIB-1:0];

endmodule : io_nib_shift_reg

// File: rtl/io_seq_adder.sv
// ---------------------------------------------------------------------------
// io_seq_adder
//   Nibble-serial ADD / SUB / ACC unit. Operands arrive NIB bits per beat,
//   LS beat first; the WIDTH-bit result is streamed back the same way.
//
//   Handshake: a beat moves on a rising clock edge where valid and ready
//   are both high. The producer of a beat holds data/valid stable until the
//   beat moves; out_data/out_valid never change while out_ready is low.
//
//   Ports:
//     wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//     in_data/in_valid/in_ready    : operand beat stream
//     op_mode                      : operation, sampled with beat 0 of A
//     out_data/out_valid/out_ready : result beat stream
//     carry_o     : carry (ADD/ACC) or borrow (SUB) of the last EXEC
//     busy_o      : high whenever the FSM is not in IDLE
//     dbg_state_o : current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module io_seq_adder
  import io_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NIB-1:0]     in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op_mode,
  output logic [NIB-1:0]     out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               carry_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] dbg_state_o
);

  localparam int BEATS = WIDTH / NIB;
  localparam int CW    = cnt_width(BEATS);

  localparam logic [CW-1:0] LAST_A_CNT = CW'(BEATS - 2);
  localparam logic [CW-1:0] LAST_CNT   = CW'(BEATS - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  op_mode_t       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic           carry_q, carry_d;

  logic           accept_st;
  logic           in_xfer;
  logic           out_xfer;
  op_mode_t       op_in;

  logic           a_shift, b_shift, res_load, res_shift;
  logic [WIDTH-1:0] a_data, b_data;
  logic [NIB-1:0] res_nib;

  logic [WIDTH-1:0] exec_result;
  logic           exec_carry;
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  logic [NIB-1:0]   a_nib_unused;
  logic [NIB-1:0]   b_nib_unused;
  logic [WIDTH-1:0] res_data_unused;

  assign op_in     = op_mode_t'(op_mode);
  assign accept_st = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_xfer   = in_valid && accept_st && !wb_rst_i;
  assign out_xfer  = out_ready && (state_q == SEND);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer && (op_in != OP_CLR)) begin
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        // Beat 0 was taken in IDLE, so the counter here runs 0..BEATS-2.
        if (in_xfer && (cnt_q == LAST_A_CNT)) begin
          state_d = (mode_q == OP_ACC) ? EXEC : LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_xfer && (cnt_q == LAST_CNT)) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = SEND;
      end
      SEND: begin
        if (out_xfer && (cnt_q == LAST_CNT)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = accept_st && !wb_rst_i;
    out_valid = (state_q == SEND);
    busy_o    = (state_q != IDLE);
    a_shift   = 1'b0;
    b_shift   = 1'b0;
    res_load  = 1'b0;
    res_shift = 1'b0;
    case (state_q)
      IDLE:    a_shift   = in_xfer && (op_in != OP_CLR);
      LOAD_A:  a_shift   = in_xfer;
      LOAD_B:  b_shift   = in_xfer;
      EXEC:    res_load  = 1'b1;
      SEND:    res_shift = out_xfer;
      default: ;
    endcase
  end

  // Result register is zero outside SEND, but gate anyway so the bus reads
  // 0 whenever no beat is offered.
  assign out_data    = out_valid ? res_nib : '0;
  assign carry_o     = carry_q;
  assign dbg_state_o = state_q;

  // -------------------------------------------------------------------------
  // Arithmetic for EXEC. ACC adds A onto the accumulator; B is unused.
  // -------------------------------------------------------------------------
  always_comb begin
    sum_w  = '0;
    diff_w = '0;
    if (mode_q == OP_ACC) begin
      sum_w = {1'b0, acc_q} + {1'b0, a_data};
    end else begin
      sum_w = {1'b0, a_data} + {1'b0, b_data};
    end
    // The borrow out of the extended subtraction is exactly (A < B).
    diff_w = {1'b0, a_data} - {1'b0, b_data};
    if (mode_q == OP_SUB) begin
      exec_result = diff_w[WIDTH-1:0];
      exec_carry  = diff_w[WIDTH];
    end else begin
      exec_result = sum_w[WIDTH-1:0];
      exec_carry  = sum_w[WIDTH];
    end
  end

  // -------------------------------------------------------------------------
  // Control registers: beat counter, latched mode, accumulator, carry
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    carry_d = carry_q;

    // Counter restarts on every state change so each phase counts from 0.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((in_xfer && (state_q != IDLE)) || out_xfer) begin
      cnt_d = cnt_q + CW'(1);
    end

    if ((state_q == IDLE) && in_xfer) begin
      mode_d = op_in;
      if (op_in == OP_CLR) begin
        acc_d   = '0;
        carry_d = 1'b0;
      end
    end

    if (state_q == EXEC) begin
      carry_d = exec_carry;
      if (mode_q == OP_ACC) begin
        acc_d = exec_result;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q   <= '0;
      mode_q  <= OP_ADD;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // -------------------------------------------------------------------------
  // Operand and result shift registers
  // -------------------------------------------------------------------------
  io_nib_shift_reg #(.WIDTH(WIDTH), .NIB(NIB)) u_opa (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (1'b0),
    .par_i       ('0),
    .shift_in_i  (a_shift),
    .nib_i       (in_data),
    .shift_out_i (1'b0),
    .data_o      (a_data),
    .nib_o       (a_nib_unused)
  );

  io_nib_shift_reg #(.WIDTH(WIDTH), .NIB(NIB)) u_opb (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (1'b0),
    .par_i       ('0),
    .shift_in_i  (b_shift),
    .nib_i       (in_data),
    .shift_out_i (1'b0),
    .data_o      (b_data),
    .nib_o       (b_nib_unused)
  );

  io_nib_shift_reg #(.WIDTH(WIDTH), .NIB(NIB)) u_res (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (res_load),
    .par_i       (exec_result),
    .shift_in_i  (1'b0),
    .nib_i       ('0),
    .shift_out_i (res_shift),
    .data_o      (res_data_unused),
    .nib_o       (res_nib)
  );

endmodule : io_seq_adder

// File: tb/tb_io_seq_adder.sv
module tb_io_seq_adder;
  import io_seq_adder_pkg::*;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int BEATS = WIDTH / NIB;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NIB-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op_mode;
  logic [NIB-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           carry_o;
  logic           busy_o;
  logic [2:0]     dbg_state;

  io_seq_adder #(.WIDTH(WIDTH), .NIB(NIB)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_mode     (op_mode),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .carry_o     (carry_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard and reference model
  // -------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_acc;
  logic             model_carry;

  // Plain arithmetic on the operation's definition.
  task automatic model_op(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint s;
    longint modv;
    modv = longint'(1) << WIDTH;
    case (m)
      2'b00: begin
        s = longint'(a) + longint'(b);
        model_carry = (s >= modv);
        exp_q.push_back(WIDTH'(s % modv));
      end
      2'b01: begin
        s = longint'(a) - longint'(b);
        model_carry = (a < b);
        if (s < 0) s = s + modv;
        exp_q.push_back(WIDTH'(s));
      end
      2'b10: begin
        s = longint'(model_acc) + longint'(a);
        model_carry = (s >= modv);
        model_acc = WIDTH'(s % modv);
        exp_q.push_back(model_acc);
      end
      default: begin
        model_acc   = '0;
        model_carry = 1'b0;
      end
    endcase
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_beat(input logic [NIB-1:0] d, input logic [1:0] m);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    op_mode  = m;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Runs one operation end to end and checks latency, result beats, carry,
  // input blocking during SEND and the return to IDLE.
  task automatic run_op(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int stall_beat, input bit rand_ready, input string name);
    int lat;
    int beat;
    int guard;
    int stalls;
    logic [WIDTH-1:0] exp_res;
    logic [WIDTH-1:0] got;

    model_op(m, a, b);
    for (int i = 0; i < BEATS; i++) begin
      drive_beat(a[i*NIB +: NIB], (i == 0) ? m : ~m);
      if (m == 2'b11) break;
    end

    if (m == 2'b11) begin
      @(negedge clk);
      total_cnt++;
      if (carry_o !== 1'b0 || busy_o !== 1'b0 || out_valid !== 1'b0) begin
        $display("FAIL %s_clr: carry=%b busy=%b out_valid=%b required 0/0/0", name, carry_o, busy_o, out_valid);
      end else pass_cnt++;
      return;
    end

    if (m != 2'b10) begin
      for (int i = 0; i < BEATS; i++) begin
        drive_beat(b[i*NIB +: NIB], $urandom_range(0, 3));
      end
    end

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    total_cnt++;
    if (lat !== 2) begin
      $display("FAIL %s_latency: first out_valid after %0d cycles required 2", name, lat);
    end else pass_cnt++;

    exp_res = exp_q.pop_front();

    // Junk input while SEND is active must be refused.
    in_valid = 1'b1;
    in_data  = NIB'($urandom);
    op_mode  = 2'b11;
    total_cnt++;
    if (in_ready !== 1'b0) begin
      $display("FAIL %s_in_ready_send: in_ready=%b required 0", name, in_ready);
    end else pass_cnt++;

    beat   = 0;
    guard  = 0;
    stalls = 3;
    got    = '0;
    while (beat < BEATS && guard < 200) begin
      if (beat == stall_beat && stalls > 0) begin
        out_ready = 1'b0;
        stalls--;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp_res[beat*NIB +: NIB]) begin
          $display("FAIL %s_stall_hold: out_valid=%b out_data=%h required 1/%h", name, out_valid, out_data,
                   exp_res[beat*NIB +: NIB]);
        end else pass_cnt++;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got[beat*NIB +: NIB] = out_data;
        beat++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;

    total_cnt++;
    if (beat != BEATS || got !== exp_res) begin
      $display("FAIL %s_result: got %h (%0d beats) required %h", name, got, beat, exp_res);
    end else pass_cnt++;
    total_cnt++;
    if (carry_o !== model_carry) begin
      $display("FAIL %s_carry: carry_o=%b required %b", name, carry_o, model_carry);
    end else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_done: out_valid=%b busy=%b in_ready=%b required 0/0/1", name, out_valid, busy_o, in_ready);
    end else pass_cnt++;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; op_mode = 2'b00; out_ready = 1'b1;
    model_acc = '0; model_carry = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0 || carry_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h carry=%b busy=%b required 0/0/0/0/0",
               in_ready, out_valid, out_data, carry_o, busy_o);
    end else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || dbg_state !== 3'(IDLE)) begin
      $display("FAIL reset_release: in_ready=%b state=%0d required 1/IDLE", in_ready, dbg_state);
    end else pass_cnt++;
  endtask

  task automatic test_add();
    run_op(2'b00, 16'h1234, 16'h0FFF, -1, 1'b0, "add_2233");
    run_op(2'b00, 16'hFFFF, 16'h0001, -1, 1'b0, "add_wrap");
  endtask

  task automatic test_sub();
    run_op(2'b01, 16'h0005, 16'h0007, -1, 1'b0, "sub_borrow");
    run_op(2'b01, 16'h0007, 16'h0005, -1, 1'b0, "sub_plain");
  endtask

  task automatic test_acc_sequence();
    run_op(2'b11, 16'h0000, 16'h0000, -1, 1'b0, "acc_clr");
    run_op(2'b10, 16'h0010, 16'h0000, -1, 1'b0, "acc_10");
    run_op(2'b10, 16'h0020, 16'h0000, -1, 1'b0, "acc_30");
    run_op(2'b00, 16'h0001, 16'h0001, -1, 1'b0, "acc_add");
    run_op(2'b10, 16'h0001, 16'h0000, -1, 1'b0, "acc_31");
  endtask

  task automatic test_backpressure();
    run_op(2'b00, 16'h1234, 16'h0FFF, 1, 1'b0, "bp_2233");
  endtask

  task automatic test_reset_mid();
    run_op(2'b00, 16'hFFFF, 16'h0001, -1, 1'b0, "rm_carry");
    for (int i = 0; i < BEATS; i++) drive_beat(NIB'(i + 3), (i == 0) ? 2'b00 : 2'b01);
    for (int i = 0; i < 2; i++) drive_beat(NIB'(i + 9), 2'b00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || carry_o !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL reset_mid: out_valid=%b carry=%b busy=%b in_ready=%b required 0/0/0/0",
               out_valid, carry_o, busy_o, in_ready);
    end else pass_cnt++;
    model_acc = '0;
    model_carry = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 16'h0003, 16'h0004, -1, 1'b0, "rm_add");
    run_op(2'b10, 16'h0001, 16'h0000, -1, 1'b0, "rm_acc");
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int k = 0; k < 25; k++) begin
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op(m, 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
             1'b1, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc_sequence();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_io_seq_adder
